// File: rtl/disp_engine_scheduler_if.sv
// Job-issue and result-stream bundle for disp_engine_scheduler.
// The scheduler uses the slave view; the job source / stream sink uses the master view.
interface disp_engine_scheduler_if #(
    parameter int COL_BITS = 10
) ();
    logic                job_valid;
    logic                job_ready;
    logic [COL_BITS-1:0] job_col;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic [7:0]          m_axis_tdata;
    logic                m_axis_tlast;

    modport slave (
        input  job_valid, job_col, m_axis_tready,
        output job_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output job_valid, job_col, m_axis_tready,
        input  job_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/disp_engine_scheduler.sv
// Round-robin issue / in-order retire scheduler for a pool of disparity engines.
// Optional per-engine watchdog enabled by defining DISP_SCHED_WDOG_EN.
module disp_engine_scheduler #(
    parameter int NUM_ENG   = 4,
    parameter int PTR_BITS  = 2,
    parameter int DISP_BITS = 6,
    parameter int COL_BITS  = 10,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int TIMEOUT   = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    disp_engine_scheduler_if.slave        bus,
    output logic [NUM_ENG-1:0]            eng_start,
    output logic [COL_BITS-1:0]           eng_col,
    output logic [NUM_ENG-1:0]            eng_clr,
    input  logic [NUM_ENG-1:0]            eng_done,
    input  logic [NUM_ENG*DISP_BITS-1:0]  eng_disp,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          err
);
    localparam int COLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROWW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [1:0] S_CLR  = 2'd0;
    localparam logic [1:0] S_FREE = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [NUM_ENG-1:0][1:0]           slot_state;
    logic [NUM_ENG-1:0][DISP_BITS-1:0] hold_data;
    logic [NUM_ENG-1:0]                stray_done;
    logic [NUM_ENG-1:0]                not_free;
    logic [NUM_ENG-1:0]                wdog_fire;

    logic [PTR_BITS-1:0] iss_ptr_reg;
    logic [PTR_BITS-1:0] ret_ptr_reg;
    logic [COLW-1:0]     out_col_reg;
    logic [ROWW-1:0]     out_row_reg;
    logic [NUM_ENG-1:0]  eng_start_reg;
    logic [COL_BITS-1:0] eng_col_reg;
    logic                frame_done_reg;
    logic                busy_reg;
    logic                err_reg;

    logic job_hs;
    logic out_hs;
    logic last_col;
    logic last_row;

    // Both handshakes depend only on slot state, so there is no combinational
    // path from job_valid/tready back to job_ready/tvalid.
    assign bus.job_ready     = (slot_state[iss_ptr_reg] == S_FREE);
    assign bus.m_axis_tvalid = (slot_state[ret_ptr_reg] == S_HOLD);
    assign bus.m_axis_tdata  = 8'(hold_data[ret_ptr_reg]);
    assign last_col          = (out_col_reg == COLW'(IMG_W - 1));
    assign last_row          = (out_row_reg == ROWW'(IMG_H - 1));
    assign bus.m_axis_tlast  = bus.m_axis_tvalid && last_col;

    assign job_hs = bus.job_valid && bus.job_ready;
    assign out_hs = bus.m_axis_tvalid && bus.m_axis_tready;

`ifdef DISP_SCHED_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_slot
        logic [1:0]           state_reg;
        logic [DISP_BITS-1:0] hold_reg;
        logic                 start_hit;
        logic                 retire_hit;
        logic                 timeout_hit;

        assign start_hit  = job_hs && (iss_ptr_reg == PTR_BITS'(gi));
        assign retire_hit = out_hs && (ret_ptr_reg == PTR_BITS'(gi));

`ifdef DISP_SCHED_WDOG_EN
        logic [WDW-1:0] wdog_reg;

        // A real done on the final watchdog cycle still wins over the timeout.
        assign timeout_hit = (state_reg == S_RUN) && !eng_done[gi] &&
                             (wdog_reg == WDW'(TIMEOUT - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wdog_reg <= '0;
            end else if (start_hit) begin
                wdog_reg <= '0;
            end else if (state_reg == S_RUN) begin
                wdog_reg <= wdog_reg + WDW'(1);
            end
        end
`else
        assign timeout_hit = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= S_CLR;
                hold_reg  <= '0;
            end else begin
                case (state_reg)
                    S_CLR:  state_reg <= S_FREE;
                    S_FREE: if (start_hit) state_reg <= S_RUN;
                    S_RUN: begin
                        if (eng_done[gi]) begin
                            state_reg <= S_HOLD;
                            hold_reg  <= eng_disp[gi*DISP_BITS +: DISP_BITS];
                        end else if (timeout_hit) begin
                            state_reg <= S_HOLD;
                            hold_reg  <= '0;
                        end
                    end
                    default: if (retire_hit) state_reg <= S_CLR;
                endcase
            end
        end

        assign slot_state[gi] = state_reg;
        assign hold_data[gi]  = hold_reg;
        assign eng_clr[gi]    = (state_reg == S_CLR);
        assign stray_done[gi] = eng_done[gi] && (state_reg != S_RUN);
        assign not_free[gi]   = (state_reg != S_FREE);
        assign wdog_fire[gi]  = timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_ptr_reg    <= '0;
            ret_ptr_reg    <= '0;
            out_col_reg    <= '0;
            out_row_reg    <= '0;
            eng_start_reg  <= '0;
            eng_col_reg    <= '0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            if (job_hs) begin
                iss_ptr_reg <= iss_ptr_reg + PTR_BITS'(1);
                eng_col_reg <= bus.job_col;
            end
            if (out_hs) begin
                ret_ptr_reg <= ret_ptr_reg + PTR_BITS'(1);
                if (last_col) begin
                    out_col_reg <= '0;
                    out_row_reg <= last_row ? '0 : out_row_reg + ROWW'(1);
                end else begin
                    out_col_reg <= out_col_reg + COLW'(1);
                end
            end
            eng_start_reg  <= job_hs ? (NUM_ENG'(1) << iss_ptr_reg) : '0;
            frame_done_reg <= out_hs && last_col && last_row;
            busy_reg       <= |not_free;
            err_reg        <= err_reg | (|stray_done) | (|wdog_fire);
        end
    end

    assign eng_start  = eng_start_reg;
    assign eng_col    = eng_col_reg;
    assign frame_done = frame_done_reg;
    assign busy       = busy_reg;
    assign err        = err_reg;
endmodule

// File: tb/tb_disp_engine_scheduler.sv
// Bench for disp_engine_scheduler: behavioural engine pool plus an in-order
// expected-result queue; IMG_W=4, IMG_H=2 so row/frame wrap is exercised.
module tb_disp_engine_scheduler;
    localparam int NUM_ENG   = 4;
    localparam int PTR_BITS  = 2;
    localparam int DISP_BITS = 6;
    localparam int COL_BITS  = 10;
    localparam int IMG_W     = 4;
    localparam int IMG_H     = 2;
    localparam int TIMEOUT   = 16;
`ifdef DISP_SCHED_WDOG_EN
    localparam int LAT_SINGLE = 10;
`else
    localparam int LAT_SINGLE = 20;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_ENG-1:0]           eng_start, eng_clr;
    logic [NUM_ENG-1:0]           eng_done = '0;
    logic [COL_BITS-1:0]          eng_col;
    logic [NUM_ENG*DISP_BITS-1:0] eng_disp = '0;
    logic                         frame_done, busy, err;

    disp_engine_scheduler_if #(.COL_BITS(COL_BITS)) bus ();

    disp_engine_scheduler #(
        .NUM_ENG(NUM_ENG), .PTR_BITS(PTR_BITS), .DISP_BITS(DISP_BITS),
        .COL_BITS(COL_BITS), .IMG_W(IMG_W), .IMG_H(IMG_H), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .eng_start(eng_start), .eng_col(eng_col), .eng_clr(eng_clr),
        .eng_done(eng_done), .eng_disp(eng_disp),
        .frame_done(frame_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int plan_disp [NUM_ENG];
    int plan_lat  [NUM_ENG];
    int cd        [NUM_ENG];
    logic [NUM_ENG-1:0] model_done, model_done_prev, stray_mask, occ, cool;
    int exp_q [$];
    int iss_cnt, ret_cnt, beat_cnt, fd_cnt, tlast_cnt;
    int cur_col, cur_disp, cur_lat;
    logic accepted;
    logic [NUM_ENG-1:0]  exp_start, exp_clr;
    logic [COL_BITS-1:0] exp_col;
    logic exp_fd;
    int tready_mode;
    logic prev_hold;
    logic [7:0] prev_tdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_ENG; k++) begin
            plan_disp[k] = 0;
            plan_lat[k]  = 0;
            cd[k]        = -1;
        end
        model_done = '0; model_done_prev = '0; stray_mask = '0; occ = '0; cool = '0;
        exp_q.delete();
        iss_cnt = 0; ret_cnt = 0; beat_cnt = 0; fd_cnt = 0; tlast_cnt = 0;
        exp_start = '0; exp_clr = '0; exp_col = '0; exp_fd = 1'b0;
        prev_hold = 1'b0; prev_tdata = '0;
    endtask

    // One clock: sample pre-edge handshakes, step the reference, check post-edge.
    task automatic cycle();
        logic jh, oh;
        int k;
        #1;
        if (prev_hold) begin
            check("tvalid_stable", bus.m_axis_tvalid, 1);
            check("tdata_stable", bus.m_axis_tdata, prev_tdata);
        end
        prev_hold  = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_tdata = bus.m_axis_tdata;
        jh = bus.job_valid && bus.job_ready;
        oh = bus.m_axis_tvalid && bus.m_axis_tready;
        cool = '0; exp_start = '0; exp_clr = '0; exp_fd = 1'b0;
        if (oh) begin
            k = ret_cnt % NUM_ENG;
            check("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("tdata", bus.m_axis_tdata, exp_q[0]);
                void'(exp_q.pop_front());
            end
            check("tlast", bus.m_axis_tlast, (beat_cnt % IMG_W) == IMG_W - 1);
            if (bus.m_axis_tlast) tlast_cnt++;
            if ((beat_cnt % (IMG_W*IMG_H)) == IMG_W*IMG_H - 1) exp_fd = 1'b1;
            beat_cnt++; ret_cnt++;
            occ[k] = 1'b0; cool[k] = 1'b1; exp_clr[k] = 1'b1;
        end
        if (jh) begin
            k = iss_cnt % NUM_ENG;
            plan_disp[k] = cur_disp;
            plan_lat[k]  = cur_lat;
            exp_q.push_back((cur_lat < 0) ? 0 : cur_disp);
            exp_start = NUM_ENG'(1) << k;
            exp_col = COL_BITS'(cur_col);
            occ[k] = 1'b1;
            iss_cnt++;
            accepted = 1'b1;
        end
        @(posedge clk); #1;
        check("eng_start", eng_start, exp_start);
        if (exp_start != '0) check("eng_col", eng_col, exp_col);
        check("eng_clr", eng_clr, exp_clr);
        check("frame_done", frame_done, exp_fd);
        if (frame_done) fd_cnt++;
        check("job_ready", bus.job_ready,
              !occ[iss_cnt % NUM_ENG] && !cool[iss_cnt % NUM_ENG]);
        model_done_prev = model_done;
        if (model_done_prev[ret_cnt % NUM_ENG] && occ[ret_cnt % NUM_ENG])
            check("done_to_tvalid", bus.m_axis_tvalid, 1);
        for (int e = 0; e < NUM_ENG; e++) begin
            if (eng_start[e]) cd[e] = plan_lat[e];
            model_done[e] = 1'b0;
            if (cd[e] == 0) begin
                model_done[e] = 1'b1;
                cd[e] = -1;
            end else if (cd[e] > 0) begin
                cd[e] = cd[e] - 1;
            end
            eng_disp[e*DISP_BITS +: DISP_BITS] = DISP_BITS'(plan_disp[e]);
        end
        eng_done = model_done | stray_mask;
        bus.m_axis_tready = (tready_mode == 2) ? ($urandom_range(0, 99) < 70) : (tready_mode == 1);
    endtask

    task automatic offer(input int col, input int disp, input int lat);
        int budget = 0;
        cur_col = col; cur_disp = disp; cur_lat = lat;
        bus.job_valid = 1'b1;
        bus.job_col = COL_BITS'(col);
        accepted = 1'b0;
        while (!accepted && budget < 300) begin
            cycle();
            budget++;
        end
        bus.job_valid = 1'b0;
        check("job_accepted", accepted, 1);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            cycle();
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.job_valid = 1'b0; bus.job_col = '0; bus.m_axis_tready = 1'b0;
        eng_done = '0; eng_disp = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_eng_clr", eng_clr, 4'b1111);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_col", eng_col, 0);
        check("rst_job_ready", bus.job_ready, 0);
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_tdata", bus.m_axis_tdata, 0);
        check("rst_tlast", bus.m_axis_tlast, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_eng_clr", eng_clr, 0);
        @(posedge clk); #1;
        check("rel_job_ready", bus.job_ready, 1);
    endtask

    initial begin
        int b;
        int ret_base;
        tready_mode = 1;
        do_reset();

        // Single job, engine 0, disp 5.
        offer(17, 5, LAT_SINGLE);
        b = 0;
        while (!bus.m_axis_tvalid && b < 60) begin cycle(); b++; end
        check("single_tvalid", bus.m_axis_tvalid, 1);
        check("single_tdata", bus.m_axis_tdata, 8'd5);
        drain();

        // Four back-to-back jobs finishing 3,1,2,0; fifth must wait for a retire.
        ret_base = ret_cnt;
        offer(100, 6, 12);
        offer(101, 7, 6);
        offer(102, 8, 9);
        offer(103, 9, 2);
        check("busy_inflight", busy, 1);
        offer(104, 33, 3);
        check("job5_after_retire", ret_cnt > ret_base, 1);
        drain();
        check("idle_busy", busy, 0);

        // Backpressure: result held for 10 cycles with tready low.
        tready_mode = 0;
        bus.m_axis_tready = 1'b0;
        offer(33, 42, 4);
        b = 0;
        while (!bus.m_axis_tvalid && b < 40) begin cycle(); b++; end
        check("bp_tvalid", bus.m_axis_tvalid, 1);
        repeat (10) cycle();
        check("bp_tdata", bus.m_axis_tdata, 8'd42);
        check("bp_no_clr", eng_clr, 0);
        tready_mode = 1;
        drain();

        // One full 4x2 frame of random jobs under random backpressure.
        do_reset();
        tready_mode = 2;
        for (int i = 0; i < 8; i++)
            offer($urandom_range(0, 639), $urandom_range(0, 63), $urandom_range(0, 12));
        drain();
        check("frame_tlast_count", tlast_cnt, 2);
        check("frame_done_count", fd_cnt, 1);

        // Stray done on a FREE slot: sticky err, stream keeps working.
        tready_mode = 1;
        check("err_before_stray", err, 0);
        stray_mask = 4'b0100;
        cycle();
        stray_mask = '0;
        cycle();
        check("err_after_stray", err, 1);
        for (int i = 0; i < 3; i++)
            offer($urandom_range(0, 639), $urandom_range(0, 63), $urandom_range(0, 12));
        drain();
        check("err_sticky", err, 1);

`ifdef DISP_SCHED_WDOG_EN
        // Hung engine: watchdog forces a zero result.
        offer(250, 17, -1);
        drain();
        check("wdog_err", err, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
